sysbus_responder: RTL and testbench
===================================

SYSBUS_RESPONDER -- requirements
Module: sysbus_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, width of req/resp beats.
REQ-002 SHALL have parameter TAG_WIDTH, 13, width of reqtag/resptag; bit TAG_WIDTH-1 = 1 read, 0 write.
REQ-003 SHALL have parameter BEATS, 8, data beats per line transfer (power of two).
REQ-004 SHALL have parameter ADDR_BITS, 10, backing store depth 2^ADDR_BITS words of DATA_WIDTH.
REQ-005 SHALL have parameter LATENCY, 4, idle cycles between last request beat and first response beat (0 legal).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port reqcyc, input, 1, initiator request beat valid.
REQ-009 SHALL have port req, input, DATA_WIDTH, address on header beat, write data on data beats.
REQ-010 SHALL have port reqtag, input, TAG_WIDTH, request tag, sampled on header beat only.
REQ-011 SHALL have port reqack, output, 1, request beat accepted this cycle.
REQ-012 SHALL have port respcyc, output, 1, response beat valid.
REQ-013 SHALL have port resp, output, DATA_WIDTH, response data.
REQ-014 SHALL have port resptag, output, TAG_WIDTH, echo of latched reqtag.
REQ-015 SHALL have port respack, input, 1, initiator accepts response beat.

Function
REQ-016 SHALL transfer a request beat only in a cycle with reqcyc=1 and reqack=1, and a response beat only in a cycle with respcyc=1 and respack=1.
REQ-017 SHALL implement states IDLE, HDR, WDATA, WAIT, RESP.
REQ-018 IDLE: reqcyc=1 at a rising edge SHALL move to HDR; reqack=0 in IDLE.
REQ-019 HDR: reqack SHALL be 1 for exactly one cycle; at its closing edge req/reqtag are latched; read -> WAIT, write -> WDATA.
REQ-020 Line base SHALL be word index req[ADDR_BITS+2:3] with low log2(BEATS) bits cleared; addresses beyond the store wrap modulo 2^ADDR_BITS.
REQ-021 WDATA: reqack SHALL equal reqcyc combinationally; each accepted beat k (0..BEATS-1) written to word base+k; after beat BEATS-1 -> WAIT.
REQ-022 WDATA with reqcyc=0 SHALL stall indefinitely with beat counter held; no timeout.
REQ-023 WAIT SHALL last exactly LATENCY cycles (counter), then -> RESP; LATENCY=0 enters RESP on the edge leaving HDR/WDATA.
REQ-024 RESP read: respcyc=1, resp = word base+k, beat k advances only on respack; after beat BEATS-1 accepted -> IDLE.
REQ-025 RESP write: single beat, resp=0, respcyc=1 until respack, then -> IDLE.
REQ-026 resp/resptag/respcyc SHALL be stable while respcyc=1 and respack=0.
REQ-027 reqcyc SHALL be ignored (reqack=0) in WAIT and RESP; next request acknowledged no earlier than one cycle after IDLE re-entry.
REQ-028 respcyc SHALL be 0 in all states except RESP; resptag SHALL equal latched reqtag for every response beat.
REQ-029 Read latency: header accepted at edge T -> first respcyc high in cycle T+1+LATENCY.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, reqack=0, respcyc=0, resp=0, resptag=0, counters=0, regardless of clock.
REQ-031 Reset mid-transfer SHALL abandon the transaction; already-written words persist, backing store is never cleared by reset.
REQ-032 First request SHALL be accepted only after reset deasserted and a rising edge with reqcyc=1.

Verification
REQ-033 Write line addr 0x40, tag 0x0005, data 0x100..0x107, respack=1 -> 1 response beat, resp=0, resptag=0x0005, respcyc at T_last+1+4.
REQ-034 Read addr 0x40, tag 0x1005 -> 8 beats 0x100..0x107, resptag=0x1005, first respcyc 5 cycles after header edge.
REQ-035 Read with respack toggled 1,0,0,1,... -> each beat held stable while respack=0, order preserved, no beat skipped/duplicated.
REQ-036 Write with reqcyc dropped 3 cycles after beat 2 -> reqack=0 during gap, resume at beat 3, readback matches.
REQ-037 reset=0 asserted mid-RESP (beat 3) between edges -> respcyc=0 same instant; after release, read of same line returns earlier written data.
REQ-038 reqcyc held high through RESP -> reqack=0 until IDLE, next HDR ack occurs one cycle after IDLE re-entry.

Source files
------------

// File: rtl/sysbus_responder.sv
// sysbus_responder: line-oriented bus target backed by a local word store.
// Accepts a header beat, optional write data, then replies after LATENCY.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   reqcyc   request beat valid from the initiator
//   req      header address or write data beat
//   reqtag   request tag; MSB set = read, clear = write
//   reqack   request beat accepted this cycle
//   respcyc  response beat valid
//   resp     response data (read words, zero for write completion)
//   resptag  latched request tag echoed with every response beat
//   respack  initiator accepts the current response beat
module sysbus_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int BEATS      = 8,
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqcyc,
  input  logic [DATA_WIDTH-1:0] req,
  input  logic [TAG_WIDTH-1:0]  reqtag,
  output logic                  reqack,
  output logic                  respcyc,
  output logic [DATA_WIDTH-1:0] resp,
  output logic [TAG_WIDTH-1:0]  resptag,
  input  logic                  respack
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);
  localparam logic [LW-1:0] LAT_LAST =
    LW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [LW-1:0] LAT_ONE = LW'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] LINE_MASK =
    ~(ADDR_BITS'(BEATS - 1));

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [BW-1:0]           beat;
  logic [LW-1:0]           lat;
  logic                    is_rd;
  logic [ADDR_BITS-1:0]    base;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_BITS-1:0]    hdr_base;
  logic [ADDR_BITS-1:0]    wr_addr;
  logic [ADDR_BITS-1:0]    rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    hdr_rd;
  logic                    wr_fire;

  // Byte address to word index; line base is aligned to BEATS words.
  assign hdr_base = req[ADDR_BITS+2:3] & LINE_MASK;
  assign hdr_rd   = reqtag[TAG_WIDTH-1];

  assign reqack  = (state == HDR) |
                   ((state == WDATA) & reqcyc);
  assign wr_fire = (state == WDATA) & reqcyc;
  assign wr_addr = base + ADDR_BITS'(beat);

  // Word that the response register loads on its next update:
  // beat 0 when entering RESP, beat k+1 when beat k is accepted.
  always_comb begin
    rd_addr = base;
    if (state == HDR) begin
      rd_addr = hdr_base;
    end else if (state == RESP) begin
      rd_addr = base + ADDR_BITS'(beat) + ADDR_ONE;
    end
  end

  assign rd_data = mem[rd_addr];

  // The store is deliberately outside the reset domain so that
  // written data survives a reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      beat    <= '0;
      lat     <= '0;
      is_rd   <= 1'b0;
      base    <= '0;
      resptag <= '0;
      resp    <= '0;
      respcyc <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reqcyc) begin
            state <= HDR;
          end
        end

        HDR: begin
          is_rd   <= hdr_rd;
          resptag <= reqtag;
          base    <= hdr_base;
          beat    <= '0;
          lat     <= '0;
          if (!hdr_rd) begin
            state <= WDATA;
          end else if (LATENCY == 0) begin
            state   <= RESP;
            respcyc <= 1'b1;
            resp    <= rd_data;
          end else begin
            state <= WAIT;
          end
        end

        WDATA: begin
          if (reqcyc) begin
            if (beat == BEAT_LAST) begin
              beat <= '0;
              if (LATENCY == 0) begin
                state   <= RESP;
                respcyc <= 1'b1;
                resp    <= '0;
              end else begin
                state <= WAIT;
              end
            end else begin
              beat <= beat + BEAT_ONE;
            end
          end
        end

        WAIT: begin
          if (lat == LAT_LAST) begin
            lat     <= '0;
            state   <= RESP;
            respcyc <= 1'b1;
            resp    <= is_rd ? rd_data : '0;
          end else begin
            lat <= lat + LAT_ONE;
          end
        end

        RESP: begin
          if (respack) begin
            if (!is_rd || (beat == BEAT_LAST)) begin
              state   <= IDLE;
              respcyc <= 1'b0;
              resp    <= '0;
              beat    <= '0;
            end else begin
              beat <= beat + BEAT_ONE;
              resp <= rd_data;
            end
          end
        end

        default: begin
          state   <= IDLE;
          respcyc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_responder.sv
// tb_sysbus_responder: directed and randomized checks of sysbus_responder
// against a word-level reference store and latency rules.
module tb_sysbus_responder;

  localparam int DW  = 64;
  localparam int TW  = 13;
  localparam int NB  = 8;
  localparam int AB  = 10;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reqcyc = 1'b0;
  logic [DW-1:0] req = '0;
  logic [TW-1:0] reqtag = '0;
  logic          reqack;
  logic          respcyc;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;
  logic          respack = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] mdl [int];
  logic [63:0] wdata [NB];

  always #5 clk = ~clk;

  sysbus_responder #(
    .DATA_WIDTH(DW),
    .TAG_WIDTH(TW),
    .BEATS(NB),
    .ADDR_BITS(AB),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqcyc(reqcyc),
    .req(req),
    .reqtag(reqtag),
    .reqack(reqack),
    .respcyc(respcyc),
    .resp(resp),
    .resptag(resptag),
    .respack(respack)
  );

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int line_base(input logic [63:0] a);
    int w;
    w = int'((a / 64'd8) % 64'(2 ** AB));
    return (w / NB) * NB;
  endfunction

  task automatic hdr(input logic [63:0] a, input logic [TW-1:0] t);
    int n;
    @(posedge clk);
    #1;
    reqcyc = 1'b1;
    req = a;
    reqtag = t;
    #1 chk("idle_ack", 64'(reqack), 64'd0);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!reqack && n < 20);
    chk("hdr_delay", 64'(n), 64'd1);
  endtask

  task automatic wait_resp(input bit hold);
    int j;
    j = 0;
    #1;
    while (!respcyc && j < 64) begin
      if (hold) chk("wait_noack", 64'(reqack), 64'd0);
      @(posedge clk);
      #2;
      j++;
    end
    chk("resp_latency", 64'(j), 64'(LAT));
  endtask

  task automatic write_line(input logic [63:0] a, input logic [TW-1:0] t,
                            input int gap_at, input int gap_len,
                            input int abort_at);
    int b;
    b = line_base(a);
    hdr(a, t);
    @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) begin
      if (k == abort_at) begin
        reqcyc = 1'b0;
        reset = 1'b0;
        #1;
        chk("wabort_ack", 64'(reqack), 64'd0);
        chk("wabort_cyc", 64'(respcyc), 64'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        return;
      end
      if (k == gap_at) begin
        reqcyc = 1'b0;
        req = '1;
        for (int g = 0; g < gap_len; g++) begin
          #1 chk("gap_ack", 64'(reqack), 64'd0);
          @(posedge clk);
          #1;
        end
      end
      reqcyc = 1'b1;
      req = wdata[k];
      #1 chk("wr_ack", 64'(reqack), 64'd1);
      @(posedge clk);
      #1;
      mdl[b + k] = wdata[k];
    end
    reqcyc = 1'b0;
    wait_resp(1'b0);
    chk("wr_cyc", 64'(respcyc), 64'd1);
    chk("wr_resp", resp, 64'd0);
    chk("wr_tag", 64'(resptag), 64'(t));
    respack = 1'b1;
    @(posedge clk);
    #2;
    chk("wr_done", 64'(respcyc), 64'd0);
    respack = 1'b0;
  endtask

  // mode 0: always accept, 1: accept pattern 1,0,0 repeating, 2: random
  task automatic read_line(input logic [63:0] a, input logic [TW-1:0] t,
                           input int mode, input int abort_at,
                           input bit hold, input logic [63:0] na,
                           input logic [TW-1:0] nt, input bit hdr_done);
    int b;
    int k;
    int cyc;
    bit ack;
    b = line_base(a);
    k = 0;
    cyc = 0;
    if (!hdr_done) hdr(a, t);
    @(posedge clk);
    #1;
    if (hold) begin
      req = na;
      reqtag = nt;
    end else begin
      reqcyc = 1'b0;
    end
    wait_resp(hold);
    while (k < NB && cyc < 200) begin
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk("rst_cyc", 64'(respcyc), 64'd0);
        chk("rst_resp", resp, 64'd0);
        chk("rst_tag", 64'(resptag), 64'd0);
        respack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        return;
      end
      chk("rd_cyc", 64'(respcyc), 64'd1);
      chk("rd_data", resp, mdl[b + k]);
      chk("rd_tag", 64'(resptag), 64'(t));
      if (hold) chk("resp_noack", 64'(reqack), 64'd0);
      case (mode)
        0: ack = 1'b1;
        1: ack = (cyc % 3 == 0);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      respack = ack;
      @(posedge clk);
      #2;
      cyc++;
      if (ack) k++;
    end
    respack = 1'b0;
    chk("rd_beats", 64'(k), 64'(NB));
    chk("rd_end", 64'(respcyc), 64'd0);
    if (hold) begin
      chk("idle_noack", 64'(reqack), 64'd0);
      @(posedge clk);
      #2;
      chk("hdr_reack", 64'(reqack), 64'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int gat;

    // reset state, with reqcyc already asserted
    reset = 1'b0;
    reqcyc = 1'b1;
    req = 64'h40;
    #1;
    chk("rst0_ack", 64'(reqack), 64'd0);
    chk("rst0_cyc", 64'(respcyc), 64'd0);
    chk("rst0_resp", resp, 64'd0);
    chk("rst0_tag", 64'(resptag), 64'd0);
    @(posedge clk);
    #2 chk("rst_hold_ack", 64'(reqack), 64'd0);
    @(posedge clk);
    #2 chk("rst_hold_ack2", 64'(reqack), 64'd0);
    #1;
    reset = 1'b1;
    reqcyc = 1'b0;

    // basic line write and readback
    for (int k = 0; k < NB; k++) wdata[k] = 64'h100 + 64'(k);
    write_line(64'h40, 13'h0005, -1, 0, -1);
    read_line(64'h40, 13'h1005, 0, -1, 1'b0, 64'h0, 13'h0, 1'b0);

    // respack throttling, unaligned header inside the same line
    read_line(64'h58, 13'h1a5a, 1, -1, 1'b0, 64'h0, 13'h0, 1'b0);

    // write with a three-cycle reqcyc gap after beat 2
    for (int k = 0; k < NB; k++) wdata[k] = 64'h200 + 64'(k);
    write_line(64'h80, 13'h0123, 3, 3, -1);
    read_line(64'h80, 13'h1123, 2, -1, 1'b0, 64'h0, 13'h0, 1'b0);

    // reset during a read response, then the data is still there
    read_line(64'h80, 13'h1111, 0, 3, 1'b0, 64'h0, 13'h0, 1'b0);
    read_line(64'h80, 13'h1112, 0, -1, 1'b0, 64'h0, 13'h0, 1'b0);

    // reset during write data keeps only the beats already taken
    for (int k = 0; k < NB; k++) wdata[k] = 64'h300 + 64'(k);
    write_line(64'h80, 13'h0007, -1, 0, 3);
    read_line(64'h80, 13'h1007, 0, -1, 1'b0, 64'h0, 13'h0, 1'b0);

    // reqcyc held through WAIT/RESP; next header aliases line 0x40
    read_line(64'h40, 13'h1005, 0, -1, 1'b1, 64'h2058, 13'h1006, 1'b0);
    read_line(64'h2058, 13'h1006, 2, -1, 1'b0, 64'h0, 13'h0, 1'b1);

    // randomized lines over the whole address space
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      for (int k = 0; k < NB; k++) wdata[k] = {$urandom, $urandom};
      gat = int'($urandom_range(0, NB));
      write_line(a, 13'($urandom_range(0, 4095)), gat,
                 int'($urandom_range(1, 3)), -1);
      read_line(a ^ (64'($urandom_range(0, 7)) << 13) ^
                64'($urandom_range(0, 63)),
                13'h1000 | 13'($urandom_range(0, 4095)),
                int'($urandom_range(0, 2)), -1, 1'b0,
                64'h0, 13'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
